// File: rtl/control_riego.sv
// control_riego: irrigation pump sequencer with per-plant dryness threshold, soak wait and dry-episode lockout
module control_riego #(
    parameter int T_RIEGO    = 100,
    parameter int T_ESPERA   = 400,
    parameter int MAX_RIEGOS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        habilitar,
    input  logic [11:0] humedad,
    input  logic        humedad_valida,
    input  logic [3:0]  tipoPlanta,
    output logic        bomba,
    output logic        alarma,
    output logic        ocupado,
    output logic [2:0]  estado
);
    localparam int TMAX = (T_RIEGO > T_ESPERA) ? T_RIEGO : T_ESPERA;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(MAX_RIEGOS + 1);

    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        MEDIR   = 3'd1,
        REGANDO = 3'd2,
        ESPERA  = 3'd3,
        BLOQUEO = 3'd4
    } estado_t;

    estado_t        st, st_n;
    logic [TW-1:0]  timer, timer_n;
    logic [CW-1:0]  contador, contador_n;
    logic [3:0]     umbral;
    logic           seco;

    assign umbral = (tipoPlanta inside {4'd1, 4'd2, 4'd3}) ? tipoPlanta : 4'd0;
    assign seco   = (humedad[11:8] == 4'd0) && (humedad[7:4] < umbral);
    assign estado = st;

    always_comb begin
        st_n       = st;
        timer_n    = timer;
        contador_n = contador;
        if (!habilitar) begin
            st_n       = REPOSO;
            timer_n    = '0;
            contador_n = '0;
        end else begin
            case (st)
                REPOSO: begin
                    st_n       = MEDIR;
                    contador_n = '0;
                end
                MEDIR: if (humedad_valida) begin
                    if (!seco) begin
                        st_n       = REPOSO;
                        contador_n = '0;
                    end else if (contador < CW'(MAX_RIEGOS)) begin
                        st_n       = REGANDO;
                        timer_n    = TW'(T_RIEGO);
                        contador_n = contador + CW'(1);
                    end else begin
                        st_n = BLOQUEO;
                    end
                end
                REGANDO: begin
                    st_n    = (timer == TW'(1)) ? ESPERA : REGANDO;
                    timer_n = (timer == TW'(1)) ? TW'(T_ESPERA) : timer - TW'(1);
                end
                ESPERA: begin
                    st_n    = (timer == TW'(1)) ? MEDIR : ESPERA;
                    timer_n = timer - TW'(1);
                end
                BLOQUEO: st_n = BLOQUEO;
                default: begin
                    st_n       = REPOSO;
                    timer_n    = '0;
                    contador_n = '0;
                end
            endcase
        end
    end

    // outputs are registered from the next state so they change on the same edge as estado
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= REPOSO;
            timer    <= '0;
            contador <= '0;
            bomba    <= 1'b0;
            alarma   <= 1'b0;
            ocupado  <= 1'b0;
        end else begin
            st       <= st_n;
            timer    <= timer_n;
            contador <= contador_n;
            bomba    <= (st_n == REGANDO);
            alarma   <= (st_n == BLOQUEO);
            ocupado  <= (st_n inside {MEDIR, REGANDO, ESPERA});
        end
    end
endmodule

// File: tb/tb_control_riego.sv
// tb_control_riego: table-driven threshold vectors plus directed multi-cycle sequences for control_riego
module tb_control_riego;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        habilitar;
    logic [11:0] humedad;
    logic        humedad_valida;
    logic [3:0]  tipoPlanta;
    logic        bomba, alarma, ocupado;
    logic [2:0]  estado;

    int checks = 0;
    int errors = 0;

    control_riego dut (
        .clk(clk), .rst_n(rst_n), .habilitar(habilitar), .humedad(humedad),
        .humedad_valida(humedad_valida), .tipoPlanta(tipoPlanta),
        .bomba(bomba), .alarma(alarma), .ocupado(ocupado), .estado(estado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tipo;
        logic [11:0] hum;
        logic        pump;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] h);
        humedad        = h;
        humedad_valida = 1'b1;
        step();
        humedad_valida = 1'b0;
    endtask

    task automatic wait_state(input string name, input int s, input int budget);
        int n = 0;
        while (int'(estado) != s && n < budget) begin
            step();
            n++;
        end
        chk(name, int'(estado), s);
    endtask

    task automatic enter_medir(input logic [3:0] t);
        habilitar = 1'b0;
        step();
        tipoPlanta = t;
        habilitar  = 1'b1;
        step();
        chk("enter_medir", int'(estado), 1);
    endtask

    initial begin
        int n;
        vecs[0] = '{4'd2,  12'h045, 1'b0};
        vecs[1] = '{4'd0,  12'h000, 1'b0};
        vecs[2] = '{4'd4,  12'h000, 1'b0};
        vecs[3] = '{4'd3,  12'h100, 1'b0};
        vecs[4] = '{4'd3,  12'h029, 1'b1};
        vecs[5] = '{4'd1,  12'h005, 1'b1};
        vecs[6] = '{4'd1,  12'h015, 1'b0};
        vecs[7] = '{4'd3,  12'h0A0, 1'b0};
        vecs[8] = '{4'd15, 12'h000, 1'b0};

        rst_n = 1'b0; habilitar = 1'b0; humedad = '0; humedad_valida = 1'b0; tipoPlanta = '0;
        step();
        step();
        chk("reset_estado", int'(estado), 0);
        chk("reset_bomba", int'(bomba), 0);
        chk("reset_alarma", int'(alarma), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        rst_n = 1'b1;
        step();
        chk("idle_hab0", int'(estado), 0);

        // REPOSO->MEDIR ignores a strobe in the same cycle
        tipoPlanta = 4'd3; habilitar = 1'b1;
        strobe(12'h005);
        chk("repose_strobe_ignored", int'(estado), 1);
        chk("repose_strobe_bomba", int'(bomba), 0);
        chk("medir_ocupado", int'(ocupado), 1);

        foreach (vecs[i]) begin
            enter_medir(vecs[i].tipo);
            strobe(vecs[i].hum);
            chk($sformatf("vec%0d_bomba", i), int'(bomba), int'(vecs[i].pump));
            chk($sformatf("vec%0d_estado", i), int'(estado), vecs[i].pump ? 2 : 0);
        end

        // dry then recovered, with an ignored strobe during ESPERA
        enter_medir(4'd3);
        strobe(12'h025);
        n = 0;
        while (bomba && n < 1000) begin
            n++;
            step();
        end
        chk("riego_len", n, 100);
        chk("espera_entered", int'(estado), 3);
        chk("espera_contador", int'(dut.contador), 1);
        n = 0;
        while (int'(estado) == 3 && n < 1000) begin
            humedad_valida = (n == 5);
            humedad        = 12'h005;
            n++;
            step();
        end
        humedad_valida = 1'b0;
        chk("espera_len", n, 400);
        chk("after_espera", int'(estado), 1);
        chk("after_espera_contador", int'(dut.contador), 1);
        strobe(12'h035);
        chk("recovered_estado", int'(estado), 0);
        chk("recovered_contador", int'(dut.contador), 0);

        // lockout after three runs
        enter_medir(4'd1);
        for (int r = 0; r < 3; r++) begin
            strobe(12'h005);
            chk($sformatf("lock_run%0d_bomba", r), int'(bomba), 1);
            wait_state($sformatf("lock_run%0d_medir", r), 1, 600);
        end
        strobe(12'h005);
        chk("lock_estado", int'(estado), 4);
        chk("lock_alarma", int'(alarma), 1);
        chk("lock_bomba", int'(bomba), 0);
        chk("lock_ocupado", int'(ocupado), 0);
        strobe(12'h000);
        step();
        chk("lock_held", int'(estado), 4);
        habilitar = 1'b0;
        step();
        chk("unlock_alarma", int'(alarma), 0);
        chk("unlock_estado", int'(estado), 0);

        // habilitar=0 wins over a simultaneous dry strobe
        enter_medir(4'd3);
        habilitar = 1'b0;
        strobe(12'h005);
        chk("simul_bomba", int'(bomba), 0);
        chk("simul_estado", int'(estado), 0);

        // abort at cycle 40 of REGANDO
        enter_medir(4'd2);
        strobe(12'h010);
        repeat (39) step();
        chk("abort_pre_bomba", int'(bomba), 1);
        habilitar = 1'b0;
        step();
        chk("abort_bomba", int'(bomba), 0);
        chk("abort_estado", int'(estado), 0);

        // asynchronous reset mid-REGANDO
        enter_medir(4'd2);
        strobe(12'h010);
        step();
        chk("prereset_bomba", int'(bomba), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_bomba", int'(bomba), 0);
        chk("async_ocupado", int'(ocupado), 0);
        chk("async_alarma", int'(alarma), 0);
        chk("async_estado", int'(estado), 0);
        chk("async_timer", int'(dut.timer), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_medir", int'(estado), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
